// File: rtl/sys2d_pkg.sv
// Shared types and default sizing for the systolic-array output deskew block.
package sys2d_pkg;

    localparam int DEF_ARRAY_WIDTH   = 4;
    localparam int DEF_ACC_WIDTH     = 32;
    localparam int DEF_FIFO_DEPTH    = 8;
    localparam int DEF_STALL_MARGIN  = 4;
    localparam int DEF_ROW_CNT_WIDTH = 16;

    localparam int PTR_W = $clog2(DEF_FIFO_DEPTH);

    typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/acc_col_fifo.sv
// Single-column show-ahead FIFO. A write becomes visible at the head one cycle later,
// and a push into a full FIFO is accepted only when the FIFO pops in the same cycle.
module acc_col_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic [$clog2(DEPTH):0] count_next_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              drop_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;
    logic [PW:0]       count_d;
    logic              push_ok;
    logic              pop_ok;
    logic              clear;

    assign clear   = !rst_ni || flush_i;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && full_o && !pop_ok;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    assign count_next_o = count_d;

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sys2d_out_deskew.sv
// Collects skewed per-column results from the array bottom into column FIFOs and
// emits complete, column-aligned rows over valid/ready, with an early stall to the array.
module sys2d_out_deskew
    import sys2d_pkg::*;
#(
    parameter int SYS_ARRAY_WIDTH = DEF_ARRAY_WIDTH,
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int STALL_MARGIN    = DEF_STALL_MARGIN,
    parameter int ROW_CNT_WIDTH   = DEF_ROW_CNT_WIDTH
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             flush,
    input  logic        [SYS_ARRAY_WIDTH-1:0]                acc_valid_in,
    input  logic signed [SYS_ARRAY_WIDTH-1:0][ACC_WIDTH-1:0] acc_data_in,
    output logic                                             drain_stall,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic signed [SYS_ARRAY_WIDTH-1:0][ACC_WIDTH-1:0] out_data,
    output logic        [ROW_CNT_WIDTH-1:0]                  out_row_cnt,
    output logic                                             overflow_err
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]              STALL_LVL = (CW+1)'(FIFO_DEPTH - STALL_MARGIN);
    localparam logic [ROW_CNT_WIDTH-1:0] ROW_ONE   = ROW_CNT_WIDTH'(1);

    logic [SYS_ARRAY_WIDTH-1:0] col_empty;
    logic [SYS_ARRAY_WIDTH-1:0] col_full;
    logic [SYS_ARRAY_WIDTH-1:0] col_drop;
    logic [CW:0]                col_cnt_next [SYS_ARRAY_WIDTH];
    logic                       pop;

    logic                       stall_q, stall_d;
    logic                       ovf_q, ovf_d;
    logic [ROW_CNT_WIDTH-1:0]   row_cnt_q, row_cnt_d;

    // A row exists only once every column holds at least one entry.
    assign out_valid = ~|col_empty;
    assign pop       = out_valid && out_ready;

    for (genvar c = 0; c < SYS_ARRAY_WIDTH; c++) begin : g_col
        acc_col_fifo #(
            .DATA_W (ACC_WIDTH),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst_ni       (reset),
            .flush_i      (flush),
            .push_i       (acc_valid_in[c]),
            .pop_i        (pop),
            .data_i       (acc_data_in[c]),
            .head_o       (out_data[c]),
            .count_next_o (col_cnt_next[c]),
            .full_o       (col_full[c]),
            .empty_o      (col_empty[c]),
            .drop_o       (col_drop[c])
        );
    end

    always_comb begin
        stall_d = 1'b0;
        for (int c = 0; c < SYS_ARRAY_WIDTH; c++) begin
            if (col_cnt_next[c] > STALL_LVL) stall_d = 1'b1;
        end
        ovf_d     = ovf_q | (|col_drop);
        row_cnt_d = pop ? row_cnt_q + ROW_ONE : row_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            stall_q   <= 1'b0;
            ovf_q     <= 1'b0;
            row_cnt_q <= '0;
        end else begin
            stall_q   <= stall_d;
            ovf_q     <= ovf_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    assign drain_stall  = stall_q;
    assign overflow_err = ovf_q;
    assign out_row_cnt  = row_cnt_q;

    // col_full is kept for visibility when probing the column buffers.
    logic unused_full;
    assign unused_full = ^col_full;

endmodule

// File: tb/tb_sys2d_out_deskew.sv
// Randomised and directed bench for sys2d_out_deskew against a queue-based row model.
module tb_sys2d_out_deskew;
    import sys2d_pkg::*;

    localparam int N      = 4;
    localparam int W      = 32;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 4;
    localparam int RCW    = 16;

    typedef logic [N-1:0][W-1:0] row_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      flush;
    logic        [N-1:0]       acc_valid_in;
    logic signed [N-1:0][W-1:0] acc_data_in;
    logic                      drain_stall;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [N-1:0][W-1:0] out_data;
    logic        [RCW-1:0]     out_row_cnt;
    logic                      overflow_err;

    always #5 clk = ~clk;

    sys2d_out_deskew #(
        .SYS_ARRAY_WIDTH (N),
        .ACC_WIDTH       (W),
        .FIFO_DEPTH      (DEPTH),
        .STALL_MARGIN    (MARGIN),
        .ROW_CNT_WIDTH   (RCW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .acc_valid_in (acc_valid_in),
        .acc_data_in  (acc_data_in),
        .drain_stall  (drain_stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row_cnt  (out_row_cnt),
        .overflow_err (overflow_err)
    );

    int checks = 0;
    int errors = 0;

    acc_t           mq [N][$];
    logic           m_stall = 1'b0;
    logic           m_ovf   = 1'b0;
    logic [RCW-1:0] m_rows  = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_valid();
        for (int c = 0; c < N; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic compare_outputs();
        logic ev;
        ev = model_valid();
        check("out_valid", {31'd0, out_valid}, {31'd0, ev});
        if (ev) begin
            for (int c = 0; c < N; c++)
                check($sformatf("out_data[%0d]", c), out_data[c], mq[c][0]);
        end
        check("drain_stall", {31'd0, drain_stall}, {31'd0, m_stall});
        check("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
        check("out_row_cnt", {16'd0, out_row_cnt}, {16'd0, m_rows});
    endtask

    // Row-level model: a row leaves when every column queue has data and ready is high.
    task automatic model_update(input logic [N-1:0] v, input row_t d, input logic rdy,
                                input logic fl, input logic rs);
        logic do_pop;
        if (!rs || fl) begin
            for (int c = 0; c < N; c++) mq[c].delete();
            m_stall = 1'b0;
            m_ovf   = 1'b0;
            m_rows  = '0;
        end else begin
            do_pop = model_valid() && rdy;
            if (do_pop) begin
                for (int c = 0; c < N; c++) void'(mq[c].pop_front());
                m_rows = m_rows + 1'b1;
            end
            for (int c = 0; c < N; c++) begin
                if (v[c]) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(acc_t'(d[c]));
                    else m_ovf = 1'b1;
                end
            end
            m_stall = 1'b0;
            for (int c = 0; c < N; c++) if (mq[c].size() > DEPTH - MARGIN) m_stall = 1'b1;
        end
    endtask

    task automatic step(input logic [N-1:0] v, input row_t d, input logic rdy,
                        input logic fl, input logic rs);
        @(negedge clk);
        compare_outputs();
        acc_valid_in = v;
        acc_data_in  = d;
        out_ready    = rdy;
        flush        = fl;
        reset        = rs;
        model_update(v, d, rdy, fl, rs);
        @(posedge clk);
        #1;
    endtask

    function automatic row_t lanes(input int base);
        row_t r;
        for (int c = 0; c < N; c++) r[c] = W'(base + c);
        return r;
    endfunction

    task automatic idle(input logic rdy);
        step('0, '0, rdy, 1'b0, 1'b1);
    endtask

    task automatic skewed_row(input int base);
        for (int t = 0; t < N; t++) step(N'(1) << t, lanes(base), 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        row_t d;
        logic [N-1:0] v;
        logic [RCW-1:0] rows0;

        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        acc_valid_in = '0; acc_data_in = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_stall", {31'd0, drain_stall}, 32'd0);
        check("rst_ovf", {31'd0, overflow_err}, 32'd0);
        check("rst_rows", {16'd0, out_row_cnt}, 32'd0);

        // Single skewed row: 100+c into column c at cycle c
        skewed_row(100);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_data", out_data[3], 32'd103);
        check("t1_data0", out_data[0], 32'd100);
        idle(1'b1);
        check("t1_rows", {16'd0, out_row_cnt}, 32'd1);
        check("t1_valid_after", {31'd0, out_valid}, 32'd0);

        // Six back-to-back skewed rows with ready held high
        rows0 = out_row_cnt;
        for (int t = 0; t < 6 + N; t++) begin
            v = '0; d = '0;
            for (int c = 0; c < N; c++) begin
                if (t - c >= 0 && t - c < 6) begin
                    v[c] = 1'b1;
                    d[c] = W'(1000 + (t - c) * 16 + c);
                end
            end
            step(v, d, 1'b1, 1'b0, 1'b1);
            check("t2_stall", {31'd0, drain_stall}, 32'd0);
        end
        idle(1'b1);
        check("t2_rows", {16'd0, out_row_cnt}, {16'd0, rows0 + 16'd6});

        // Backpressure: five full rows held, stall rises after the fifth lands
        for (int r = 0; r < 5; r++) begin
            step('1, lanes(2000 + r * 8), 1'b0, 1'b0, 1'b1);
            check($sformatf("t3_stall_%0d", r), {31'd0, drain_stall}, {31'd0, r == 4});
            check("t3_hold", out_data[1], 32'd2001);
        end
        for (int r = 0; r < 6; r++) idle(1'b1);
        check("t3_drained", {31'd0, out_valid}, 32'd0);

        // Overflow on column 0, then complete the rows and drain
        for (int i = 0; i < 9; i++) step(4'b0001, lanes(200 + i * 4), 1'b0, 1'b0, 1'b1);
        check("t4_ovf", {31'd0, overflow_err}, 32'd1);
        for (int i = 0; i < 8; i++) step(4'b1110, lanes(500 + i * 4), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) idle(1'b1);
        check("t4_ovf_sticky", {31'd0, overflow_err}, 32'd1);
        step('0, '0, 1'b0, 1'b1, 1'b1);
        check("t4_flush_ovf", {31'd0, overflow_err}, 32'd0);

        // Full columns, push column 2 while popping
        for (int i = 0; i < 8; i++) step('1, lanes(300 + i * 8), 1'b0, 1'b0, 1'b1);
        d = '0; d[2] = 32'hFFFF_F999;
        step(4'b0100, d, 1'b1, 1'b0, 1'b1);
        check("t5_no_ovf", {31'd0, overflow_err}, 32'd0);
        step(4'b1011, lanes(400), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) idle(1'b1);
        check("t5_empty", {31'd0, out_valid}, 32'd0);

        // Flush mid-row, then reset mid-row; the next row must still align
        step(4'b0001, lanes(600), 1'b0, 1'b0, 1'b1);
        step(4'b0010, lanes(600), 1'b0, 1'b0, 1'b1);
        step('1, lanes(700), 1'b1, 1'b1, 1'b1);
        check("t6_flush_rows", {16'd0, out_row_cnt}, 32'd0);
        check("t6_flush_valid", {31'd0, out_valid}, 32'd0);
        skewed_row(800);
        idle(1'b1);
        check("t6_flush_next", {16'd0, out_row_cnt}, 32'd1);
        step(4'b0001, lanes(900), 1'b0, 1'b0, 1'b1);
        step(4'b0010, lanes(900), 1'b0, 1'b0, 1'b1);
        step('1, lanes(950), 1'b1, 1'b0, 1'b0);
        check("t6_rst_rows", {16'd0, out_row_cnt}, 32'd0);
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        skewed_row(820);
        idle(1'b1);
        check("t6_rst_next", {16'd0, out_row_cnt}, 32'd1);

        // Random traffic, mostly honouring drain_stall, with rare flush/reset
        for (int i = 0; i < 1500; i++) begin
            v = N'($urandom);
            if (m_stall && $urandom_range(0, 7) != 0) v = '0;
            for (int c = 0; c < N; c++) d[c] = $urandom;
            step(v, d, $urandom_range(0, 9) < 6, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        compare_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
